mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch port (F stage) and the data port (M stage) of the 5-stage pipeline.
- Sequences each memory access, returns read data to the owning port, and generates stall requests that the hazard unit ORs into its fetch and whole-pipeline stalls.
- Fixed priority: the data port (older instruction) beats fetch.

Parameters:
ADDR_W, 8, memory word-address width
DATA_W, 32, data width
MEM_LAT, 1, read latency of memory in cycles (legal 1..4)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
if_req  in  1  fetch read request, level, held until if_ready or flush
if_addr  in  ADDR_W  fetch address, stable while if_req
if_rdata  out  DATA_W  fetched instruction, registered
if_ready  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request, level, held until dm_ready
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, registered
dm_ready  out  1  one-cycle completion pulse for data port
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
stall_fetch  out  1  if_req & ~if_ready, combinational
stall_mem  out  1  dm_req & ~dm_ready, combinational

Behaviour:
- Clock is clk; reset is synchronous, active-low on rst_n.
- Reset: FSM to IDLE. if_ready, dm_ready, mem_en, mem_we = 0. if_rdata, dm_rdata, mem_addr, mem_wdata = 0. Latency counter 0.
- Reset mid-access: the in-flight read is discarded and no ready pulse is issued.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If dm_req, latch owner=DM, dm_we, dm_addr, dm_wdata; go to ACCESS.
  - Else if if_req, latch owner=IF, we=0, if_addr; go to ACCESS.
  - Else stay in IDLE.
  - Both requests in the same cycle: DM wins; IF waits with stall_fetch high.
- ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values (one cycle only).
  - Store: go to RESP.
  - Load: load counter with MEM_LAT and go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 1, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP: pulse the owner's ready for exactly one cycle; go to IDLE.
  - No new grant is issued in the RESP cycle.
  - Any req still high in the following IDLE cycle is a new request.
- Latency (request first seen in IDLE at cycle 0): ACCESS at cycle 1; load ready at cycle 2+MEM_LAT; store ready at cycle 2. Minimum spacing between back-to-back accesses is 3+MEM_LAT cycles (loads) or 3 cycles (stores).
- Flush: if_req may drop while owner=IF before RESP.
  - The memory access still completes internally.
  - if_ready is suppressed and if_rdata keeps its old value.
  - Return to IDLE after the normal latency.
- dm_req must not drop before dm_ready; a drop while owner=DM is ignored and the transaction completes, but dm_ready is suppressed.
- if_rdata and dm_rdata hold their value until overwritten by the next completed read for that port.
- mem_addr and mem_wdata hold their last value outside ACCESS; mem_we is 0 outside ACCESS.
- Addresses and data pass through unmodified; no width conversion.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined: adds output conflict_cnt (16 bits). It increments by 1 in every cycle where if_req=1 and the FSM is not serving IF (blocked fetch). It saturates at 0xFFFF and is reset to 0 by rst_n.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with if_req=1 → all outputs 0, no mem_en. Release rst_n → mem_en=1 one cycle later with mem_addr=if_addr.
- Single fetch, MEM_LAT=1, if_addr=0x04, memory returns 0x00A00093 → mem_en at cycle 1, if_ready at cycle 3, if_rdata=0x00A00093, stall_fetch high cycles 0-2.
- Simultaneous request: if_req (0x08) and dm_req load (0x02) at cycle 0 → DM is served first with dm_ready at cycle 3. IF gets ACCESS at cycle 5 and if_ready at cycle 7.
- Store: dm_we=1, addr=0x03, wdata=0xDEADBEEF → mem_en=mem_we=1 at cycle 1 with those values; dm_ready at cycle 2; subsequent load of 0x03 returns 0xDEADBEEF.
- Flush: if_req drops at cycle 2 of a MEM_LAT=3 fetch → no if_ready, if_rdata unchanged, FSM returns to IDLE at cycle 6. A dm_req at cycle 4 is granted at cycle 6.
- Mid-access reset: rst_n=0 during WAIT → next cycle IDLE, no ready pulse. With MEM_ARB_STATS_EN, conflict_cnt=0; during the simultaneous-request test, conflict_cnt=5 after IF is granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch (IF) and data (DM) ports, DM has priority
// Optional MEM_ARB_STATS_EN adds a saturating blocked-fetch counter on conflict_cnt.
module mem_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_fetch,
    output logic              stall_mem
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_grant_dm;
    logic               w_grant_if;
    logic               w_grant;
    logic               w_to_resp;
    logic               w_drop;
    logic               w_dropped;
    logic               w_capture;

    logic               r_owner_dm;
    logic               r_flush;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_dm_rdata;
    logic               r_if_ready;
    logic               r_dm_ready;

    always_comb begin
        w_next     = r_state;
        w_grant_dm = 1'b0;
        w_grant_if = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dm_req) begin
                    w_grant_dm = 1'b1;
                    w_next     = S_ACCESS;
                end else if (if_req) begin
                    w_grant_if = 1'b1;
                    w_next     = S_ACCESS;
                end
            end
            S_ACCESS: w_next = r_mem_we ? S_RESP : S_WAIT;
            S_WAIT:   if (r_cnt <= CNT_W'(1)) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_grant   = w_grant_dm | w_grant_if;
    assign w_to_resp = (r_state != S_RESP) && (w_next == S_RESP);

    // A requester that lets go mid-transaction forfeits its ready pulse and read data.
    assign w_drop    = (r_state != S_IDLE) && (r_owner_dm ? ~dm_req : ~if_req);
    assign w_dropped = r_flush | w_drop;
    assign w_capture = (r_state == S_WAIT) && (r_cnt <= CNT_W'(1)) && ~w_dropped;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner_dm  <= 1'b0;
            r_flush     <= 1'b0;
            r_cnt       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
        end else begin
            r_state  <= w_next;
            // The memory strobe is registered at grant so it is high exactly for the ACCESS cycle.
            r_mem_en <= w_grant;
            r_mem_we <= w_grant_dm & dm_we;

            if (w_grant) begin
                r_owner_dm <= w_grant_dm;
                r_flush    <= 1'b0;
                r_mem_addr <= w_grant_dm ? dm_addr : if_addr;
                if (w_grant_dm) begin
                    r_mem_wdata <= dm_wdata;
                end
            end else if (w_drop) begin
                r_flush <= 1'b1;
            end

            if (r_state == S_ACCESS) begin
                r_cnt <= CNT_W'(MEM_LAT);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_capture) begin
                if (r_owner_dm) begin
                    r_dm_rdata <= mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end

            r_if_ready <= w_to_resp & ~r_owner_dm & ~w_dropped;
            r_dm_ready <= w_to_resp &  r_owner_dm & ~w_dropped;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;
    logic        w_serving_if;

    assign w_serving_if = (r_state != S_IDLE) && ~r_owner_dm;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (if_req && !w_serving_if && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

    assign if_rdata    = r_if_rdata;
    assign dm_rdata    = r_dm_rdata;
    assign if_ready    = r_if_ready;
    assign dm_ready    = r_dm_ready;
    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign stall_fetch = if_req & ~r_if_ready;
    assign stall_mem   = dm_req & ~r_dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with MEM_LAT=1 and MEM_LAT=3 instances
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    typedef struct {
        bit          is_dm;
        bit          is_st;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;
    exp_t sb1[$];
    exp_t sb3[$];

    function automatic logic [31:0] memval(input logic [7:0] a);
        if (a == 8'h04) return 32'h00A00093;
        return {8'hC0, a, ~a, a};
    endfunction

    logic        rst1_n = 1'b0, if1_req = 1'b0, dm1_req = 1'b0, dm1_we = 1'b0;
    logic [7:0]  if1_addr = '0, dm1_addr = '0;
    logic [31:0] dm1_wdata = '0;
    logic [31:0] if1_rdata, dm1_rdata, m1_wdata, m1_rdata;
    logic        if1_ready, dm1_ready, m1_en, m1_we, sf1, sm1;
    logic [7:0]  m1_addr;

    logic        rst3_n = 1'b0, if3_req = 1'b0, dm3_req = 1'b0, dm3_we = 1'b0;
    logic [7:0]  if3_addr = '0, dm3_addr = '0;
    logic [31:0] dm3_wdata = '0;
    logic [31:0] if3_rdata, dm3_rdata, m3_wdata, m3_rdata;
    logic        if3_ready, dm3_ready, m3_en, m3_we, sf3, sm3;
    logic [7:0]  m3_addr;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] cc1, cc3;
`endif

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n),
        .if_req(if1_req), .if_addr(if1_addr), .if_rdata(if1_rdata), .if_ready(if1_ready),
        .dm_req(dm1_req), .dm_we(dm1_we), .dm_addr(dm1_addr), .dm_wdata(dm1_wdata),
        .dm_rdata(dm1_rdata), .dm_ready(dm1_ready),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m1_rdata), .stall_fetch(sf1), .stall_mem(sm1)
`ifdef MEM_ARB_STATS_EN
        , .conflict_cnt(cc1)
`endif
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n),
        .if_req(if3_req), .if_addr(if3_addr), .if_rdata(if3_rdata), .if_ready(if3_ready),
        .dm_req(dm3_req), .dm_we(dm3_we), .dm_addr(dm3_addr), .dm_wdata(dm3_wdata),
        .dm_rdata(dm3_rdata), .dm_ready(dm3_ready),
        .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
        .mem_rdata(m3_rdata), .stall_fetch(sf3), .stall_mem(sm3)
`ifdef MEM_ARB_STATS_EN
        , .conflict_cnt(cc3)
`endif
    );

    // Memory models: read data is valid only in the cycle MEM_LAT after mem_en, filler otherwise.
    logic [31:0] wm1 [256];
    bit          wv1 [256];
    logic [31:0] p1;
    always @(posedge clk) begin
        p1 <= (m1_en && !m1_we) ? (wv1[m1_addr] ? wm1[m1_addr] : memval(m1_addr)) : 32'hBAD0BAD0;
        if (m1_en && m1_we) begin
            wm1[m1_addr] <= m1_wdata;
            wv1[m1_addr] <= 1'b1;
        end
    end
    assign m1_rdata = p1;

    logic [31:0] p3 [3];
    always @(posedge clk) begin
        p3[0] <= (m3_en && !m3_we) ? memval(m3_addr) : 32'hBAD0BAD0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign m3_rdata = p3[2];

    always @(negedge clk) begin : mon1
        exp_t e;
        if (mon_en && (if1_ready || dm1_ready)) begin
            n_tests++;
            if (sb1.size() == 0) begin
                n_fail++;
                $display("FAIL dut1_unexpected_ready: if_ready=%b dm_ready=%b at cycle %0d, required none", if1_ready, dm1_ready, cyc);
            end else begin
                e = sb1.pop_front();
                if (e.cyc != cyc || e.is_dm != dm1_ready || e.is_dm == if1_ready ||
                    (!e.is_st && (e.is_dm ? dm1_rdata : if1_rdata) !== e.data)) begin
                    n_fail++;
                    $display("FAIL dut1_response: cycle %0d dm=%b ifd=%h dmd=%h, required cycle %0d dm=%b data=%h",
                             cyc, dm1_ready, if1_rdata, dm1_rdata, e.cyc, e.is_dm, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (mon_en && (if3_ready || dm3_ready)) begin
            n_tests++;
            if (sb3.size() == 0) begin
                n_fail++;
                $display("FAIL dut3_unexpected_ready: if_ready=%b dm_ready=%b at cycle %0d, required none", if3_ready, dm3_ready, cyc);
            end else begin
                e = sb3.pop_front();
                if (e.cyc != cyc || e.is_dm != dm3_ready || e.is_dm == if3_ready ||
                    (!e.is_st && (e.is_dm ? dm3_rdata : if3_rdata) !== e.data)) begin
                    n_fail++;
                    $display("FAIL dut3_response: cycle %0d dm=%b ifd=%h dmd=%h, required cycle %0d dm=%b data=%h",
                             cyc, dm3_ready, if3_rdata, dm3_rdata, e.cyc, e.is_dm, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int t0;
        if1_req = 1'b1; if1_addr = 8'h10;
        step();
        mon_en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_tests++;
            if (m1_en !== 1'b0 || m1_we !== 1'b0 || if1_ready !== 1'b0 || dm1_ready !== 1'b0 ||
                if1_rdata !== 32'h0 || dm1_rdata !== 32'h0 || m1_addr !== 8'h0 || m1_wdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: en=%b we=%b ifr=%b dmr=%b ifd=%h dmd=%h addr=%h wd=%h, required all 0",
                         m1_en, m1_we, if1_ready, dm1_ready, if1_rdata, dm1_rdata, m1_addr, m1_wdata);
            end
            step();
        end
        rst1_n = 1'b1; rst3_n = 1'b1;
        t0 = cyc;
        sb1.push_back('{1'b0, 1'b0, memval(8'h10), t0 + 3});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_tests++;
                if (m1_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_release_c0: mem_en=%b, required 0", m1_en);
                end
            end
            if (c == 1) begin
                n_tests++;
                if (m1_en !== 1'b1 || m1_addr !== 8'h10 || m1_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_release_access: en=%b addr=%h we=%b, required 1 10 0", m1_en, m1_addr, m1_we);
                end
            end
            step();
            if (c == 3) if1_req = 1'b0;
        end
        n_tests++;
        if (sb1.size() != 0) begin
            n_fail++;
            $display("FAIL reset_pending: %0d responses outstanding, required 0", sb1.size());
        end
    endtask

    task automatic test_single_fetch();
        int t0;
        if1_addr = 8'h04; if1_req = 1'b1;
        t0 = cyc;
        sb1.push_back('{1'b0, 1'b0, 32'h00A00093, t0 + 3});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (sf1 !== (c < 3) || m1_en !== (c == 1)) begin
                n_fail++;
                $display("FAIL fetch_cycle%0d: stall_fetch=%b mem_en=%b, required %b %b", c, sf1, m1_en, c < 3, c == 1);
            end
            if (c == 3) begin
                n_tests++;
                if (if1_rdata !== 32'h00A00093) begin
                    n_fail++;
                    $display("FAIL fetch_rdata: %h, required 00a00093", if1_rdata);
                end
            end
            step();
            if (c == 3) if1_req = 1'b0;
        end
        n_tests++;
        if (sb1.size() != 0) begin
            n_fail++;
            $display("FAIL fetch_pending: %0d outstanding, required 0", sb1.size());
        end
    endtask

    task automatic test_simultaneous();
        int t0;
        logic [15:0] base;
        base = '0;
        if1_addr = 8'h08; if1_req = 1'b1;
        dm1_addr = 8'h02; dm1_we = 1'b0; dm1_req = 1'b1;
        t0 = cyc;
        sb1.push_back('{1'b1, 1'b0, memval(8'h02), t0 + 3});
        sb1.push_back('{1'b0, 1'b0, memval(8'h08), t0 + 7});
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
`ifdef MEM_ARB_STATS_EN
            if (c == 0) base = cc1;
            if (c == 5) begin
                n_tests++;
                if (cc1 - base !== 16'd5) begin
                    n_fail++;
                    $display("FAIL simul_conflict_cnt: delta %0d, required 5", cc1 - base);
                end
            end
`endif
            n_tests++;
            if (m1_en !== (c == 1 || c == 5) || sf1 !== (c < 7)) begin
                n_fail++;
                $display("FAIL simul_cycle%0d: mem_en=%b stall_fetch=%b, required %b %b", c, m1_en, sf1, c == 1 || c == 5, c < 7);
            end
            if (c == 1 || c == 5) begin
                n_tests++;
                if (m1_addr !== ((c == 1) ? 8'h02 : 8'h08)) begin
                    n_fail++;
                    $display("FAIL simul_addr_c%0d: %h, required %h", c, m1_addr, (c == 1) ? 8'h02 : 8'h08);
                end
            end
            step();
            if (c == 3) dm1_req = 1'b0;
            if (c == 7) if1_req = 1'b0;
        end
        n_tests++;
        if (sb1.size() != 0 || base === 16'hxxxx) begin
            n_fail++;
            $display("FAIL simul_pending: %0d outstanding, required 0", sb1.size());
        end
    endtask

    task automatic test_store_load();
        int t0;
        dm1_we = 1'b1; dm1_addr = 8'h03; dm1_wdata = 32'hDEADBEEF; dm1_req = 1'b1;
        t0 = cyc;
        sb1.push_back('{1'b1, 1'b1, 32'h0, t0 + 2});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_tests++;
                if (m1_en !== 1'b1 || m1_we !== 1'b1 || m1_addr !== 8'h03 || m1_wdata !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL store_access: en=%b we=%b addr=%h wd=%h, required 1 1 03 deadbeef", m1_en, m1_we, m1_addr, m1_wdata);
                end
            end
            if (c == 2) begin
                n_tests++;
                if (m1_en !== 1'b0 || m1_we !== 1'b0 || m1_wdata !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL store_after: en=%b we=%b wd=%h, required 0 0 deadbeef", m1_en, m1_we, m1_wdata);
                end
            end
            step();
            if (c == 2) dm1_we = 1'b0;
        end
        t0 = cyc;
        sb1.push_back('{1'b1, 1'b0, 32'hDEADBEEF, t0 + 3});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (sm1 !== (c < 3)) begin
                n_fail++;
                $display("FAIL load_stall_mem_c%0d: %b, required %b", c, sm1, c < 3);
            end
            step();
            if (c == 3) dm1_req = 1'b0;
        end
        n_tests++;
        if (sb1.size() != 0 || dm1_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL store_load_result: %0d outstanding dm_rdata=%h, required 0 deadbeef", sb1.size(), dm1_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        dm1_we = 1'b1; dm1_addr = 8'h20; dm1_wdata = 32'h11111111; dm1_req = 1'b1;
        t0 = cyc;
        sb1.push_back('{1'b1, 1'b1, 32'h0, t0 + 2});
        sb1.push_back('{1'b1, 1'b1, 32'h0, t0 + 5});
        sb1.push_back('{1'b1, 1'b0, 32'h22222222, t0 + 9});
        sb1.push_back('{1'b1, 1'b0, 32'h11111111, t0 + 13});
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            n_tests++;
            if (m1_en !== (c == 1 || c == 4 || c == 7 || c == 11)) begin
                n_fail++;
                $display("FAIL b2b_mem_en_c%0d: %b, required %b", c, m1_en, c == 1 || c == 4 || c == 7 || c == 11);
            end
            step();
            case (c)
                2:  begin dm1_addr = 8'h21; dm1_wdata = 32'h22222222; end
                5:  dm1_we = 1'b0;
                9:  dm1_addr = 8'h20;
                13: dm1_req = 1'b0;
                default: ;
            endcase
        end
        n_tests++;
        if (sb1.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_pending: %0d outstanding, required 0", sb1.size());
        end
    endtask

    task automatic test_mid_reset();
        int t0;
        if3_addr = 8'h07; if3_req = 1'b1;
        t0 = cyc;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            step();
        end
        rst3_n = 1'b0;
        @(negedge clk);
        step();
        rst3_n = 1'b1;
        sb3.push_back('{1'b0, 1'b0, memval(8'h07), t0 + 9});
        for (int c = 4; c < 10; c++) begin
            @(negedge clk);
            if (c == 4) begin
                n_tests++;
                if (m3_en !== 1'b0 || if3_ready !== 1'b0 || if3_rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL midreset_state: en=%b ready=%b rdata=%h, required 0 0 0", m3_en, if3_ready, if3_rdata);
                end
`ifdef MEM_ARB_STATS_EN
                n_tests++;
                if (cc3 !== 16'd0) begin
                    n_fail++;
                    $display("FAIL midreset_conflict_cnt: %0d, required 0", cc3);
                end
`endif
            end
            if (c == 5) begin
                n_tests++;
                if (m3_en !== 1'b1 || m3_addr !== 8'h07) begin
                    n_fail++;
                    $display("FAIL midreset_regrant: en=%b addr=%h, required 1 07", m3_en, m3_addr);
                end
            end
            step();
            if (c == 9) if3_req = 1'b0;
        end
        n_tests++;
        if (sb3.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_pending: %0d outstanding, required 0", sb3.size());
        end
    endtask

    task automatic test_flush();
        int t0;
        if3_addr = 8'h05; if3_req = 1'b1;
        t0 = cyc;
        sb3.push_back('{1'b1, 1'b0, memval(8'h09), t0 + 11});
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_tests++;
            if (m3_en !== (c == 1 || c == 7)) begin
                n_fail++;
                $display("FAIL flush_mem_en_c%0d: %b, required %b", c, m3_en, c == 1 || c == 7);
            end
            if (c == 6) begin
                n_tests++;
                if (if3_rdata !== memval(8'h07)) begin
                    n_fail++;
                    $display("FAIL flush_if_rdata: %h, required %h", if3_rdata, memval(8'h07));
                end
            end
            if (c == 7) begin
                n_tests++;
                if (m3_addr !== 8'h09 || m3_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_dm_grant: addr=%h we=%b, required 09 0", m3_addr, m3_we);
                end
            end
            if (c == 4) begin
                n_tests++;
                if (sm3 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL flush_stall_mem: %b, required 1", sm3);
                end
            end
            step();
            if (c == 1) if3_req = 1'b0;
            if (c == 3) begin dm3_we = 1'b0; dm3_addr = 8'h09; dm3_req = 1'b1; end
            if (c == 11) dm3_req = 1'b0;
        end
        n_tests++;
        if (sb3.size() != 0) begin
            n_fail++;
            $display("FAIL flush_pending: %0d outstanding, required 0", sb3.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_store_load();
        test_back_to_back();
        test_mid_reset();
        test_flush();
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
